ic_bd_tm_pingpong_ctrl: RTL

IC_BD_TM_PINGPONG_CTRL -- requirements
Module: ic_bd_tm_pingpong_ctrl

---
 rtl/ic_bd_tm_pingpong_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ic_bd_tm_pingpong_ctrl.sv
// ic_bd_tm_pingpong_ctrl
//
// Purpose:
//   Ping-pong (NBUF-way) controller for the transpose memory that sits
//   between the row pass (stage 1) and the column pass (stage 2) of an
//   NxN binDCT. Stage 1 writes one row per cycle into the current write
//   buffer. Stage 2 reads whole blocks back in the order they were
//   written. The controller only produces enables, addresses and
//   selects. The data RAMs live outside this block.
//
// Handshake:
//   A row is accepted in a cycle where in_valid=1 and in_ready=1.
//   in_ready depends only on registered state and never on in_valid.
//   On the read side, a read is issued in a cycle where rd_ready=1 and
//   the read buffer holds a complete block. Its data appears one cycle
//   later, qualified by out_valid and out_sel.
//
// Ports:
//   clk, reset_n   clock; synchronous active-low reset
//   in_valid       stage-1 row valid
//   in_ready       write buffer has room for the row
//   tm_wr_en       one-hot buffer write enable (NBUF)
//   tm_wr_addr     row index written (N_LOG2)
//   tm_rd_en       one-hot buffer read enable (NBUF)
//   tm_rd_addr     row index read (N_LOG2)
//   rd_ready       stage-2 can consume a row this cycle
//   out_valid      read data valid (one cycle after tm_rd_en)
//   out_sel        buffer select for the output mux, aligned with out_valid
//   blk_done       pulses with out_valid for the last row of a block
//   fill_cnt       number of full, unread buffers (0..NBUF)
//   ovf            sticky: a row was offered while in_ready=0
module ic_bd_tm_pingpong_ctrl #(
    parameter int N_LOG2 = 3,
    parameter int NBUF   = 2,
    parameter int BUF_W  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [NBUF-1:0]   tm_wr_en,
    output logic [N_LOG2-1:0] tm_wr_addr,
    output logic [NBUF-1:0]   tm_rd_en,
    output logic [N_LOG2-1:0] tm_rd_addr,
    input  logic              rd_ready,
    output logic              out_valid,
    output logic [BUF_W-1:0]  out_sel,
    output logic              blk_done,
    output logic [BUF_W:0]    fill_cnt,
    output logic              ovf
);

    // Row N-1 is all ones in an N_LOG2-bit counter.
    localparam logic [N_LOG2-1:0] ROW_LAST = '1;
    localparam logic [BUF_W-1:0]  SEL_LAST = BUF_W'(NBUF - 1);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_t;

    rd_state_t state, state_nxt;

    logic [BUF_W-1:0]  wr_sel, rd_sel;
    logic [BUF_W-1:0]  wr_sel_inc, rd_sel_inc;
    logic [N_LOG2-1:0] wr_row, rd_row;
    logic [NBUF-1:0]   full;
    logic [NBUF-1:0]   wr_oh, rd_oh, rd_nxt_oh;
    logic              wr_fire, rd_fire;
    logic              fill, free;
    logic              rd_buf_full;

    // Buffer selects and their one-hot decodes. The selects count modulo
    // NBUF, so they never reach a code that has no buffer.
    always_comb begin
        wr_sel_inc = (wr_sel == SEL_LAST) ? '0 : wr_sel + BUF_W'(1);
        rd_sel_inc = (rd_sel == SEL_LAST) ? '0 : rd_sel + BUF_W'(1);
        wr_oh      = '0;
        rd_oh      = '0;
        rd_nxt_oh  = '0;
        for (int b = 0; b < NBUF; b++) begin
            wr_oh[b]     = (wr_sel == BUF_W'(b));
            rd_oh[b]     = (rd_sel == BUF_W'(b));
            rd_nxt_oh[b] = (rd_sel_inc == BUF_W'(b));
        end
    end

    // Write side. A full buffer is never written because in_ready gates
    // acceptance.
    always_comb begin
        in_ready   = ~|(full & wr_oh);
        wr_fire    = reset_n & in_valid & in_ready;
        fill       = wr_fire & (wr_row == ROW_LAST);
        tm_wr_en   = wr_fire ? wr_oh : '0;
        tm_wr_addr = wr_row;
    end

    // Read side. The full flags are registered, so a block that completes
    // in this cycle is seen as readable from the next cycle. From IDLE,
    // the first row of a full buffer is issued in the same cycle the FSM
    // leaves IDLE. This keeps fill-to-read latency at one cycle and avoids
    // a bubble when the next block finishes just as the current one
    // drains. In READ, the current buffer is full by construction.
    always_comb begin
        rd_buf_full = |(full & rd_oh);
        rd_fire     = reset_n & rd_ready & ((state == READ) | rd_buf_full);
        free        = rd_fire & (rd_row == ROW_LAST);
        tm_rd_en    = rd_fire ? rd_oh : '0;
        tm_rd_addr  = rd_row;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rd_fire) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                // Keep streaming if the following block is already complete.
                if (free) begin
                    state_nxt = (|(full & rd_nxt_oh)) ? READ : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_sel    <= '0;
            wr_row    <= '0;
            rd_sel    <= '0;
            rd_row    <= '0;
            full      <= '0;
            fill_cnt  <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_sel   <= '0;
            blk_done  <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_row <= wr_row + N_LOG2'(1);
                if (fill) begin
                    wr_sel <= wr_sel_inc;
                end
            end
            if (rd_fire) begin
                rd_row <= rd_row + N_LOG2'(1);
                if (free) begin
                    rd_sel <= rd_sel_inc;
                end
            end
            // A fill and a free in the same cycle always target different
            // buffers (one is full, the other is not), so the two masks
            // never collide.
            full <= (full | (fill ? wr_oh : '0)) & ~(free ? rd_oh : '0);
            case ({fill, free})
                2'b10:   fill_cnt <= fill_cnt + (BUF_W+1)'(1);
                2'b01:   fill_cnt <= fill_cnt - (BUF_W+1)'(1);
                default: fill_cnt <= fill_cnt;
            endcase
            if (in_valid && !in_ready) begin
                ovf <= 1'b1;
            end
            // One-cycle read latency of the transpose RAM.
            out_valid <= rd_fire;
            out_sel   <= rd_sel;
            blk_done  <= free;
        end
    end

endmodule
